// File: rtl/bcd_display_feeder.sv
// Sequential binary-to-BCD converter feeding the four-digit seven-segment driver.
// One double-dabble step per SHIFT cycle; bcd/ovf only change on the COMMIT edge.
module bcd_display_feeder #(
  parameter int IN_W = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [IN_W-1:0] in_data,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [15:0]     bcd,
  output logic            ovf,
  output logic            done
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SHIFT  = 2'd1;
  localparam logic [1:0] COMMIT = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [IN_W-1:0] bin_sr_q, bin_sr_d;
  logic [19:0]     scr_q, scr_d;
  logic [4:0]      cnt_q, cnt_d;
  logic [15:0]     bcd_q, bcd_d;
  logic            ovf_q, ovf_d;
  logic            done_q, done_d;

  // Scratch after the add-3 step; bit 19 is dropped by the shift, so only 19 bits are kept.
  logic [18:0]     scr_adj;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_adj
      assign scr_adj[gi*4 +: 4] = (scr_q[gi*4 +: 4] >= 4'd5) ? scr_q[gi*4 +: 4] + 4'd3
                                                             : scr_q[gi*4 +: 4];
    end
  endgenerate

  assign scr_adj[18:16] = (scr_q[19:16] >= 4'd5) ? scr_q[18:16] + 3'd3 : scr_q[18:16];

  always_comb begin
    state_d  = state_q;
    bin_sr_d = bin_sr_q;
    scr_d    = scr_q;
    cnt_d    = cnt_q;
    bcd_d    = bcd_q;
    ovf_d    = ovf_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          bin_sr_d = in_data;
          scr_d    = '0;
          cnt_d    = '0;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        scr_d    = {scr_adj, bin_sr_q[IN_W-1]};
        bin_sr_d = {bin_sr_q[IN_W-2:0], 1'b0};
        cnt_d    = cnt_q + 5'd1;
        if (cnt_q == 5'(IN_W - 1)) state_d = COMMIT;
      end
      COMMIT: begin
        if (scr_q[19:16] != 4'd0) begin
          bcd_d = 16'hEEEE;
          ovf_d = 1'b1;
        end else begin
          bcd_d = scr_q[15:0];
          ovf_d = 1'b0;
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      bin_sr_q <= '0;
      scr_q    <= '0;
      cnt_q    <= '0;
      bcd_q    <= '0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      bin_sr_q <= bin_sr_d;
      scr_q    <= scr_d;
      cnt_q    <= cnt_d;
      bcd_q    <= bcd_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
    end
  end

  assign in_ready = (state_q == IDLE);
  assign bcd      = bcd_q;
  assign ovf      = ovf_q;
  assign done     = done_q;

endmodule

// File: doc/bcd_display_feeder.md
# bcd_display_feeder

Sequential binary-to-BCD converter sitting directly upstream of the four-digit seven-segment display driver. It accepts a binary value from the processor's output port, converts it to four packed BCD digits with a one-bit-per-cycle shift-and-add-3 (double-dabble) engine, and presents a 16-bit value that stays stable between updates. The display then shows decimal 0000–9999 instead of hex. Values above 9999 show "EEEE".

## Interface

Parameters:
- IN_W, default 16: binary input width. Legal range 4..16.

Ports:
- clk, input, 1: single system clock. All state updates on the rising edge.
- rst_n, input, 1: reset. Asynchronous, active-low. Asserts immediately; deassertion is synchronous to clk.
- in_data, input, IN_W: unsigned binary value to convert.
- in_valid, input, 1: in_data is valid this cycle.
- in_ready, output, 1: converter can accept a value this cycle. Combinational, equal to (state == IDLE).
- bcd, output, 16: packed BCD digits {thousands, hundreds, tens, ones}. Drives the display value input directly. Registered.
- ovf, output, 1: last committed value exceeded 9999. Registered.
- done, output, 1: one-cycle pulse, high in the cycle after bcd/ovf update. Registered.

## Operation

- State machine: IDLE, SHIFT, COMMIT.
- IDLE:
  - in_ready=1.
  - On a rising edge with in_valid=1, capture in_data into shift register bin_sr (IN_W bits).
  - Clear the 20-bit scratch register (5 BCD nibbles) and clear bit counter cnt.
  - Next state is SHIFT.
- SHIFT, each cycle:
  - Every scratch nibble ≥5 gets +3 (4-bit add, no carry between nibbles).
  - Then shift {scratch, bin_sr} left by one, feeding 0 into the bin_sr LSB.
  - cnt increments.
  - After the shift where cnt reaches IN_W-1 (IN_W shifts total), next state is COMMIT.
  - cnt width is 5 bits.
- COMMIT, one cycle:
  - At the edge leaving COMMIT: if scratch[19:16]≠0, set bcd ← 16'hEEEE and ovf ← 1. Otherwise set bcd ← scratch[15:0] and ovf ← 0.
  - done ← 1. Next state is IDLE.
- done is cleared on every edge except the COMMIT edge.
- bcd and ovf change only at the COMMIT edge and hold their value otherwise. The display never sees partial results.
- in_valid while busy (SHIFT/COMMIT) is ignored: no capture, no queuing. The upstream must hold in_valid until it sees in_ready.
- For IN_W ≤ 13, ovf is always 0, since the maximum is 8191.
- in_data is sampled only at the accept edge. Later changes to in_data do not affect a conversion in progress.

## Timing

- Reset values: state=IDLE, bcd=16'h0000, ovf=0, done=0, in_ready=1 (display shows "0000").
- Accept happens at edge E0 (IDLE, in_valid=1).
- Shifts occur at edges E1..E_IN_W. Commit occurs at edge E_{IN_W+1}.
- done is high in the cycle after E_{IN_W+1}. Accept-to-output latency is IN_W+1 edges (17 for IN_W=16).
- in_ready is low from E0 until E_{IN_W+1}, and high again in the done cycle. A new value may be accepted in the done cycle.
- Maximum throughput: one conversion per IN_W+2 cycles.
- Reset mid-conversion: rst_n low immediately aborts. bcd returns to 0 and ovf and done return to 0. The partially converted value is discarded and nothing is committed.
- Simultaneous in_valid and a COMMIT cycle: not accepted, because in_ready=0. The same value is accepted one cycle later if in_valid is still held.

## Test plan

- Reset then idle → bcd=16'h0000, ovf=0, done=0, in_ready=1. rst_n low with no clock → outputs clear asynchronously.
- in_data=16'd1234 accepted at E0 → bcd stays 0000 through E16. bcd=16'h1234, ovf=0 at E17. done high exactly one cycle.
- Boundaries: 0 → 16'h0000. 9999 → 16'h9999, ovf=0. 10000 → 16'hEEEE, ovf=1. 65535 → 16'hEEEE, ovf=1. Then 42 → 16'h0042, ovf cleared.
- in_valid held continuously with values 7 then 58:
  - 7 is captured at E0. 58 is ignored until in_ready returns.
  - 58 is accepted in the done cycle.
  - bcd goes 0007 then 0058. Conversions are spaced 18 cycles apart.
- rst_n pulsed low at E8 of a conversion of 4321 → bcd=0000, done never pulses, in_ready=1. A fresh conversion of 4321 afterwards yields 16'h4321.
- IN_W=8 build: in_data=255 → bcd=16'h0255 after 9 edges, ovf=0. in_data changed during SHIFT → result still 0255.
